stack_op_sequencer: RTL
=======================

STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

Interface
REQ-001 Parameters SHALL be: STACK_BASE, default 32'h0000_0999, highest legal SP; STACK_LIMIT, default 32'h0000_0800, lowest legal SP; ACK_TIMEOUT, default 8, max wait cycles for mem_ack.
REQ-002 Ports SHALL be: clock_4 in 1, sole clock, rising edge.
REQ-003 reset in 1, synchronous, active-high.
REQ-004 cmd_valid in 1, command request.
REQ-005 cmd_op in 2, 2'b01 push, 2'b10 pop, others no-op.
REQ-006 push_data in 32, value to push.
REQ-007 stack_addr in 32, current SP from the stack address register.
REQ-008 cmd_ready out 1, high only in IDLE.
REQ-009 mem_addr out 32, data memory address.
REQ-010 mem_wdata out 32, memory write data.
REQ-011 mem_we out 1, memory write strobe.
REQ-012 mem_re out 1, memory read strobe.
REQ-013 mem_ack in 1, memory completion.
REQ-014 mem_rdata in 32, read data, valid with mem_ack.
REQ-015 read_or_write out 4, 4'h5 = SP write, else 4'h0.
REQ-016 write_data out 32, new SP value.
REQ-017 pop_valid out 1, one-cycle pop result strobe.
REQ-018 pop_data out 32, popped value.
REQ-019 err out 1, one-cycle error strobe.
REQ-020 err_code out 2: 01 overflow, 10 underflow, 11 timeout; holds until the next err.

Function
REQ-021 FSM states SHALL be IDLE, WRITE, READ, UPDATE; all outputs SHALL be registered.
REQ-022 Accept SHALL occur when cmd_valid && cmd_ready && cmd_op is 01 or 10; the block SHALL latch stack_addr as sp_q and push_data at accept; no-op codes SHALL be ignored and the block SHALL stay in IDLE.
REQ-023 Push accept SHALL go to WRITE when (sp_q - 4) >= STACK_LIMIT (unsigned, 32-bit); otherwise it SHALL pulse err with err_code=01 and stay in IDLE, with no memory access.
REQ-024 Pop accept SHALL go to READ when (sp_q + 4) <= STACK_BASE; otherwise it SHALL pulse err with err_code=10 and stay in IDLE.
REQ-025 WRITE SHALL drive mem_we=1, mem_addr=sp_q-4 and mem_wdata=latched push_data, starting the cycle after accept.
REQ-026 READ SHALL drive mem_re=1 and mem_addr=sp_q.
REQ-027 mem_we/mem_re SHALL stay high until the cycle in which mem_ack=1 is sampled, and SHALL drop the following cycle.
REQ-028 In READ, the block SHALL capture mem_rdata in the ack cycle.
REQ-029 After ack, the FSM SHALL go to UPDATE for exactly one cycle: read_or_write=4'h5, write_data=sp_q-4 (push) or sp_q+4 (pop).
REQ-030 For a pop, pop_valid=1 and pop_data=captured value SHALL be asserted in that same UPDATE cycle.
REQ-031 The FSM SHALL return to IDLE after UPDATE.
REQ-032 Minimum command latency (zero-wait ack) SHALL be: accept at cycle N, strobe at N+1, UPDATE at N+2, cmd_ready high at N+3.
REQ-033 A wait counter SHALL clear on entry to WRITE/READ and increment each non-ack cycle; on reaching ACK_TIMEOUT without ack, the block SHALL drop the strobe, pulse err with code 11, return to IDLE and skip UPDATE (SP unchanged).
REQ-034 mem_ack SHALL be ignored outside WRITE/READ.
REQ-035 read_or_write SHALL be 4'h0 and pop_valid and err SHALL be 0 in every cycle not listed above.
REQ-036 SP arithmetic SHALL be 32-bit modulo; no alignment check.
REQ-037 Bound checks SHALL be inclusive: push is legal down to SP-4 == STACK_LIMIT; pop is legal up to SP+4 == STACK_BASE.

Reset
REQ-038 Reset SHALL put the FSM in IDLE with: cmd_ready=1 (effective the cycle after reset deasserts), mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, read_or_write=4'h0, write_data=0, pop_valid=0, pop_data=0, err=0, err_code=0, wait counter=0.
REQ-039 Reset asserted mid-operation SHALL abort the operation with no UPDATE and no error pulse.
REQ-040 Reset SHALL dominate cmd_valid and mem_ack in the same cycle.

Verification
REQ-041 Push: stack_addr=0x999, push 0xDEADBEEF, ack one cycle after strobe -> mem_we with addr 0x995, data 0xDEADBEEF; then one cycle with read_or_write=5 and write_data=0x995.
REQ-042 Pop: stack_addr=0x995, mem_rdata=0x12345678 at ack -> mem_re with addr 0x995; UPDATE with write_data=0x999, pop_valid=1, pop_data=0x12345678.
REQ-043 Bounds: pop at stack_addr=0x999 -> err with code 10 and no strobe; push at 0x803 -> err with code 01; push at 0x804 -> legal, addr 0x800.
REQ-044 Timeout: push with mem_ack held low -> mem_we high for 8 cycles, then err with code 11, read_or_write stays 0, cmd_ready returns.
REQ-045 Reset mid-READ (cycle 2 of wait) -> next cycle IDLE, mem_re=0, no pop_valid, no err.
REQ-046 cmd_op=2'b11 or cmd_valid during a busy state -> ignored, no memory strobe, no SP write.

Source files
------------

// File: rtl/stack_op_sequencer_if.sv
// rtl/stack_op_sequencer_if.sv - command, memory and SP-update signals of the stack op sequencer
interface stack_op_sequencer_if;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [31:0] push_data;
    logic [31:0] stack_addr;
    logic        cmd_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [3:0]  read_or_write;
    logic [31:0] write_data;
    logic        pop_valid;
    logic [31:0] pop_data;
    logic        err;
    logic [1:0]  err_code;

    modport master (
        output cmd_valid, cmd_op, push_data, stack_addr, mem_ack, mem_rdata,
        input  cmd_ready, mem_addr, mem_wdata, mem_we, mem_re,
               read_or_write, write_data, pop_valid, pop_data, err, err_code
    );

    modport slave (
        input  cmd_valid, cmd_op, push_data, stack_addr, mem_ack, mem_rdata,
        output cmd_ready, mem_addr, mem_wdata, mem_we, mem_re,
               read_or_write, write_data, pop_valid, pop_data, err, err_code
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - push/pop sequencer: bounds check, memory access, SP update
module stack_op_sequencer #(
    parameter logic [31:0] STACK_BASE  = 32'h0000_0999,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input logic               clock_4,
    input logic               reset,
    stack_op_sequencer_if.slave bus
);
    localparam int WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, UPDATE} state_t;

    state_t            state;
    logic [31:0]       sp_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic        push_req;
    logic        pop_req;
    logic [31:0] sp_dec_in;
    logic [31:0] sp_inc_in;

    assign push_req  = bus.cmd_valid && bus.cmd_ready && (bus.cmd_op == 2'b01);
    assign pop_req   = bus.cmd_valid && bus.cmd_ready && (bus.cmd_op == 2'b10);
    assign sp_dec_in = bus.stack_addr - 32'd4;
    assign sp_inc_in = bus.stack_addr + 32'd4;

    always_ff @(posedge clock_4) begin
        if (reset) begin
            state             <= IDLE;
            sp_q              <= '0;
            wait_cnt          <= '0;
            bus.cmd_ready     <= 1'b1;
            bus.mem_addr      <= '0;
            bus.mem_wdata     <= '0;
            bus.mem_we        <= 1'b0;
            bus.mem_re        <= 1'b0;
            bus.read_or_write <= 4'h0;
            bus.write_data    <= '0;
            bus.pop_valid     <= 1'b0;
            bus.pop_data      <= '0;
            bus.err           <= 1'b0;
            bus.err_code      <= 2'b00;
        end else begin
            // single-cycle strobes default low; err_code is sticky
            bus.err           <= 1'b0;
            bus.pop_valid     <= 1'b0;
            bus.read_or_write <= 4'h0;

            case (state)
                IDLE: begin
                    if (push_req || pop_req) begin
                        sp_q <= bus.stack_addr;
                    end
                    if (push_req) begin
                        if (sp_dec_in >= STACK_LIMIT) begin
                            bus.mem_addr  <= sp_dec_in;
                            bus.mem_wdata <= bus.push_data;
                            bus.mem_we    <= 1'b1;
                            bus.cmd_ready <= 1'b0;
                            wait_cnt      <= '0;
                            state         <= WRITE;
                        end else begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 2'b01;
                        end
                    end else if (pop_req) begin
                        if (sp_inc_in <= STACK_BASE) begin
                            bus.mem_addr  <= bus.stack_addr;
                            bus.mem_re    <= 1'b1;
                            bus.cmd_ready <= 1'b0;
                            wait_cnt      <= '0;
                            state         <= READ;
                        end else begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 2'b10;
                        end
                    end
                end

                WRITE, READ: begin
                    if (bus.mem_ack) begin
                        bus.mem_we        <= 1'b0;
                        bus.mem_re        <= 1'b0;
                        bus.read_or_write <= 4'h5;
                        if (state == WRITE) begin
                            bus.write_data <= sp_q - 32'd4;
                        end else begin
                            bus.write_data <= sp_q + 32'd4;
                            bus.pop_valid  <= 1'b1;
                            bus.pop_data   <= bus.mem_rdata;
                        end
                        state <= UPDATE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // give up: SP is left untouched, so UPDATE is skipped
                        bus.mem_we    <= 1'b0;
                        bus.mem_re    <= 1'b0;
                        bus.err       <= 1'b1;
                        bus.err_code  <= 2'b11;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                UPDATE: begin
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end

                default: begin
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule
